// File: rtl/memory_ctrl.sv
// memory_ctrl: single-port request/response controller with a byte-addressed
// DRAM region and a UART region that feeds a small transmit queue.
//
// Ports
//   clk, reset           : clock and asynchronous active-low reset
//   req_valid/req_ready  : request handshake (ready only while idle)
//   req_write, req_addr,
//   req_wdata, req_wstrb : request payload (byte strobes, little-endian)
//   resp_valid/resp_ready: response handshake, payload held until accepted
//   resp_rdata,resp_error: response payload
//   tx_valid/tx_ready,
//   tx_data              : UART byte stream drained from the transmit queue
module memory_ctrl #(
  parameter int          DATA_BYTES   = 4,
  parameter int          DEPTH        = 4096,
  parameter logic [31:0] DRAM_BASE    = 32'h8000_0000,
  parameter logic [31:0] UART_BASE    = 32'h1000_0000,
  parameter logic [31:0] UART_SIZE    = 32'h100,
  parameter int          READ_LATENCY = 1,
  parameter int          TXQ_DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [31:0]             req_addr,
  input  logic [8*DATA_BYTES-1:0] req_wdata,
  input  logic [DATA_BYTES-1:0]   req_wstrb,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [8*DATA_BYTES-1:0] resp_rdata,
  output logic                    resp_error,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [7:0]              tx_data
);

  localparam int DW = 8 * DATA_BYTES;
  localparam int AW = $clog2(DEPTH);
  localparam int QW = (TXQ_DEPTH > 1) ? $clog2(TXQ_DEPTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [1:0] KIND_ERR  = 2'd0;
  localparam logic [1:0] KIND_DRAM = 2'd1;
  localparam logic [1:0] KIND_UART = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          error_q, error_d;
  logic [1:0]    kind_q;
  logic          write_q;
  logic [AW-1:0] off_q;
  logic [7:0]    wbyte_q;
  logic          wstrb0_q;

  logic [7:0]    mem [DEPTH];
  logic [DW-1:0] memRead;

  logic [7:0]    txMem_q [TXQ_DEPTH];
  logic [QW-1:0] txWr_q, txRd_q;
  logic [QW:0]   txCount_q;
  logic          txFull, txEmpty, push, pop;

  logic [31:0]   dramOff, uartOff;
  logic          dramHit, uartHit, accept;

  // Address decode; offsets are taken by subtraction so a window near the
  // top of the address space cannot overflow the upper-bound compare.
  always_comb begin
    dramOff = req_addr - DRAM_BASE;
    uartOff = req_addr - UART_BASE;
    dramHit = (req_addr >= DRAM_BASE) && (dramOff < 32'(DEPTH)) &&
              ((req_addr & 32'(DATA_BYTES - 1)) == 32'd0);
    uartHit = (req_addr >= UART_BASE) && (uartOff < UART_SIZE);
  end

  assign req_ready  = (state_q == IDLE);
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_error = error_q;

  assign txFull   = (txCount_q == (QW+1)'(TXQ_DEPTH));
  assign txEmpty  = (txCount_q == '0);
  assign tx_valid = !txEmpty;
  assign tx_data  = txEmpty ? 8'd0 : txMem_q[txRd_q];
  assign pop      = tx_valid && tx_ready;
  assign push     = (state_q == WAIT) && (kind_q == KIND_UART) && write_q &&
                    wstrb0_q && !txFull;

  // DRAM storage is deliberately outside the reset domain; writes commit on
  // the acceptance edge so a later reset cannot undo them.
  always_ff @(posedge clk) begin
    if (reset && accept && req_write && dramHit) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (req_wstrb[i]) begin
          mem[dramOff[AW-1:0] + AW'(i)] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  // Little-endian word assembly from the latched offset.
  always_comb begin
    memRead = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      memRead[8*i +: 8] = mem[off_q + AW'(i)];
    end
  end

  // Next-state logic; the response payload is computed on the WAIT->RESP
  // transition and then frozen while RESP waits for resp_ready.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    error_d = error_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = WAIT;
          cnt_d   = (dramHit && !req_write) ? 2'(READ_LATENCY - 1) : 2'd0;
        end
      end
      WAIT: begin
        case (kind_q)
          KIND_DRAM: begin
            if (write_q || cnt_q == 2'd0) begin
              state_d = RESP;
              rdata_d = write_q ? '0 : memRead;
              error_d = 1'b0;
            end else begin
              cnt_d = cnt_q - 2'd1;
            end
          end
          KIND_UART: begin
            if (write_q) begin
              if (!wstrb0_q || !txFull) begin
                state_d = RESP;
                rdata_d = '0;
                error_d = 1'b0;
              end
            end else begin
              state_d    = RESP;
              rdata_d    = '0;
              rdata_d[0] = !txFull;
              rdata_d[1] = txEmpty;
              error_d    = 1'b0;
            end
          end
          default: begin
            state_d = RESP;
            rdata_d = '0;
            error_d = 1'b1;
          end
        endcase
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and response registers, plus the request fields needed after
  // the acceptance edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      rdata_q  <= '0;
      error_q  <= 1'b0;
      kind_q   <= KIND_ERR;
      write_q  <= 1'b0;
      off_q    <= '0;
      wbyte_q  <= 8'd0;
      wstrb0_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
      if (accept) begin
        kind_q   <= dramHit ? KIND_DRAM : (uartHit ? KIND_UART : KIND_ERR);
        write_q  <= req_write;
        off_q    <= dramOff[AW-1:0];
        wbyte_q  <= req_wdata[7:0];
        wstrb0_q <= req_wstrb[0];
      end
    end
  end

  // Transmit queue; push is gated on the count at the start of the cycle, so
  // a full queue never accepts even when a pop happens on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      txWr_q    <= '0;
      txRd_q    <= '0;
      txCount_q <= '0;
      for (int i = 0; i < TXQ_DEPTH; i++) begin
        txMem_q[i] <= 8'd0;
      end
    end else begin
      if (push) begin
        txMem_q[txWr_q] <= wbyte_q;
        txWr_q <= (txWr_q == QW'(TXQ_DEPTH - 1)) ? '0 : txWr_q + QW'(1);
      end
      if (pop) begin
        txRd_q <= (txRd_q == QW'(TXQ_DEPTH - 1)) ? '0 : txRd_q + QW'(1);
      end
      if (push && !pop) begin
        txCount_q <= txCount_q + (QW+1)'(1);
      end else if (pop && !push) begin
        txCount_q <= txCount_q - (QW+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_memory_ctrl.sv
// Directed testbench for memory_ctrl. The main instance runs with
// READ_LATENCY=3; a second instance with READ_LATENCY=4 shares the payload
// and tx_ready inputs but has its own handshakes and is used for the
// reset-during-read scenario.
module tb_memory_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, resp_ready, tx_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        req_ready, resp_valid, resp_error, tx_valid;
  logic [31:0] resp_rdata;
  logic [7:0]  tx_data;

  logic        req_valid4, resp_ready4;
  logic        req_ready4, resp_valid4, resp_error4, tx_valid4;
  logic [31:0] resp_rdata4;
  logic [7:0]  tx_data4;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  memory_ctrl #(.READ_LATENCY(3)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data)
  );

  memory_ctrl #(.READ_LATENCY(4)) dut4 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid4), .req_ready(req_ready4),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid4), .resp_ready(resp_ready4),
    .resp_rdata(resp_rdata4), .resp_error(resp_error4),
    .tx_valid(tx_valid4), .tx_ready(tx_ready), .tx_data(tx_data4)
  );

  // One comparison point: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Presents a request to the main instance and returns at the negedge
  // following its acceptance edge.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb);
    @(negedge clk);
    req_write = wr; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    req_valid = 1'b1;
    checkOutput("reqReadyBeforeAccept", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Counts cycles from the acceptance edge until resp_valid, bounded.
  task automatic waitResp(output int lat);
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  // Completes the pending response and checks the return to idle.
  task automatic finishResp();
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    checkOutput("reqReadyAfterResp", {31'd0, req_ready}, 32'd1);
    checkOutput("respValidAfterResp", {31'd0, resp_valid}, 32'd0);
  endtask

  // Full transaction with latency, data and error checks.
  task automatic doAccess(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input int expLat, input logic [31:0] expData,
                          input logic expErr);
    int lat;
    applyStimulus(wr, addr, wdata, strb);
    waitResp(lat);
    checkOutput({tag, "_lat"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_err"}, {31'd0, resp_error}, {31'd0, expErr});
    if (!wr) checkOutput({tag, "_rdata"}, resp_rdata, expData);
    finishResp();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] expBytes [5];
    int         lat;
    expBytes[0] = 8'h41; expBytes[1] = 8'h42; expBytes[2] = 8'h43;
    expBytes[3] = 8'h44; expBytes[4] = 8'h45;

    reset = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    resp_ready = 1'b0; tx_ready = 1'b0; req_valid4 = 1'b0; resp_ready4 = 1'b0;

    // Reset state
    @(negedge clk);
    checkOutput("rstReqReady", {31'd0, req_ready}, 32'd1);
    checkOutput("rstRespValid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rstRdata", resp_rdata, 32'd0);
    checkOutput("rstError", {31'd0, resp_error}, 32'd0);
    checkOutput("rstTxValid", {31'd0, tx_valid}, 32'd0);
    checkOutput("rstTxData", {24'd0, tx_data}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // UART status on an empty queue, then DRAM write/read/strobe merge
    doAccess("uartStatEmpty", 1'b0, 32'h1000_0000, 32'd0, 4'h0, 1, 32'h3, 1'b0);
    doAccess("dramWr", 1'b1, 32'h8000_0010, 32'h1122_3344, 4'hF, 1, 32'd0, 1'b0);
    doAccess("dramRd", 1'b0, 32'h8000_0010, 32'd0, 4'h0, 3, 32'h1122_3344, 1'b0);
    doAccess("dramWrStrb", 1'b1, 32'h8000_0010, 32'hAABB_CCDD, 4'b0101, 1, 32'd0, 1'b0);
    doAccess("dramRdMerge", 1'b0, 32'h8000_0010, 32'd0, 4'h0, 3, 32'h11BB_33DD, 1'b0);

    // Error accesses must not disturb memory
    doAccess("errMisalignRd", 1'b0, 32'h8000_0002, 32'd0, 4'h0, 1, 32'd0, 1'b1);
    doAccess("errZeroRd", 1'b0, 32'h0000_0000, 32'd0, 4'h0, 1, 32'd0, 1'b1);
    doAccess("errMisalignWr", 1'b1, 32'h8000_0012, 32'hFFFF_FFFF, 4'hF, 1, 32'd0, 1'b1);
    doAccess("errPastEndRd", 1'b0, 32'h8000_1000, 32'd0, 4'h0, 1, 32'd0, 1'b1);
    doAccess("dramRdUnchanged", 1'b0, 32'h8000_0010, 32'd0, 4'h0, 3, 32'h11BB_33DD, 1'b0);

    // Window edges
    doAccess("dramWrLast", 1'b1, 32'h8000_0FFC, 32'hDEAD_BEEF, 4'hF, 1, 32'd0, 1'b0);
    doAccess("uartLastByte", 1'b0, 32'h1000_00FF, 32'd0, 4'h0, 1, 32'h3, 1'b0);
    doAccess("uartPastEnd", 1'b0, 32'h1000_0100, 32'd0, 4'h0, 1, 32'd0, 1'b1);

    // Response held under back-pressure
    applyStimulus(1'b0, 32'h8000_0FFC, 32'd0, 4'h0);
    waitResp(lat);
    checkOutput("holdLat", 32'(lat), 32'd3);
    for (int i = 0; i < 4; i++) begin
      checkOutput("holdRespValid", {31'd0, resp_valid}, 32'd1);
      checkOutput("holdRdata", resp_rdata, 32'hDEAD_BEEF);
      checkOutput("holdReqReady", {31'd0, req_ready}, 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    finishResp();

    // UART queue fill, non-pushing write, stall on full, ordered drain
    for (int i = 0; i < 4; i++) begin
      doAccess("uartWr", 1'b1, 32'h1000_0000, {24'd0, expBytes[i]}, 4'h1, 1, 32'd0, 1'b0);
    end
    checkOutput("txValidFull", {31'd0, tx_valid}, 32'd1);
    checkOutput("txDataHead", {24'd0, tx_data}, 32'h41);
    doAccess("uartStatFull", 1'b0, 32'h1000_0004, 32'd0, 4'h0, 1, 32'd0, 1'b0);
    doAccess("uartWrNoStrb", 1'b1, 32'h1000_0000, 32'h58, 4'b1110, 1, 32'd0, 1'b0);
    applyStimulus(1'b1, 32'h1000_0000, {24'd0, expBytes[4]}, 4'h1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("stallRespValid", {31'd0, resp_valid}, 32'd0);
      checkOutput("stallReqReady", {31'd0, req_ready}, 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("drainTxValid", {31'd0, tx_valid}, 32'd1);
      checkOutput("drainTxData", {24'd0, tx_data}, {24'd0, expBytes[i]});
      @(posedge clk);
      @(negedge clk);
    end
    tx_ready = 1'b0;
    checkOutput("drainEmpty", {31'd0, tx_valid}, 32'd0);
    checkOutput("stallRespDone", {31'd0, resp_valid}, 32'd1);
    checkOutput("stallRespErr", {31'd0, resp_error}, 32'd0);
    finishResp();
    doAccess("uartStatDrained", 1'b0, 32'h1000_0000, 32'd0, 4'h0, 1, 32'h3, 1'b0);

    // Reset during a latency-4 read on the second instance
    @(negedge clk);
    req_write = 1'b1; req_addr = 32'h1000_0000; req_wdata = 32'h5A; req_wstrb = 4'h1;
    req_valid4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid4 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("d4UartRespValid", {31'd0, resp_valid4}, 32'd1);
    resp_ready4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready4 = 1'b0;
    checkOutput("d4TxValid", {31'd0, tx_valid4}, 32'd1);
    checkOutput("d4TxData", {24'd0, tx_data4}, 32'h5A);
    req_write = 1'b0; req_addr = 32'h8000_0010; req_wstrb = 4'h0;
    req_valid4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("d4ReadPending", {31'd0, resp_valid4}, 32'd0);
      checkOutput("d4ReqReadyBusy", {31'd0, req_ready4}, 32'd0);
      if (i < 2) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    reset = 1'b0;
    #1;
    checkOutput("d4RstRespValid", {31'd0, resp_valid4}, 32'd0);
    checkOutput("d4RstReqReady", {31'd0, req_ready4}, 32'd1);
    checkOutput("d4RstTxValid", {31'd0, tx_valid4}, 32'd0);
    checkOutput("d4RstTxData", {24'd0, tx_data4}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("d4PostRstRespValid", {31'd0, resp_valid4}, 32'd0);
      checkOutput("d4PostRstReqReady", {31'd0, req_ready4}, 32'd1);
      checkOutput("d4PostRstTxValid", {31'd0, tx_valid4}, 32'd0);
    end

    // DRAM contents survive reset
    doAccess("dramAfterReset", 1'b0, 32'h8000_0010, 32'd0, 4'h0, 3, 32'h11BB_33DD, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/memory_ctrl.md
MEMORY_CTRL -- requirements
Module: memory_ctrl

Interface
REQ-001 SHALL provide parameter DATA_BYTES, default 4: bytes per data word; legal values 1, 2, 4, 8.
REQ-002 SHALL provide parameter DEPTH, default 4096: DRAM size in bytes; a power of 2.
REQ-003 SHALL provide parameter DRAM_BASE, default 32'h8000_0000: DRAM region base address.
REQ-004 SHALL provide parameter UART_BASE, default 32'h1000_0000, and parameter UART_SIZE, default 32'h100: UART region.
REQ-005 SHALL provide parameter READ_LATENCY, default 1: DRAM read latency in cycles; legal range 1..4.
REQ-006 SHALL provide parameter TXQ_DEPTH, default 4: UART transmit queue entries; a power of 2.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-008 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have ports req_valid (input, 1) and req_ready (output, 1): request handshake.
REQ-010 SHALL have ports req_write (input, 1), req_addr (input, 32), req_wdata (input, 8*DATA_BYTES) and req_wstrb (input, DATA_BYTES): request payload.
REQ-011 SHALL have ports resp_valid (output, 1) and resp_ready (input, 1): response handshake.
REQ-012 SHALL have ports resp_rdata (output, 8*DATA_BYTES) and resp_error (output, 1): response payload.
REQ-013 SHALL have ports tx_valid (output, 1), tx_ready (input, 1) and tx_data (output, 8): UART byte stream.

Function
REQ-014 SHALL implement an FSM with states IDLE, WAIT and RESP; req_ready SHALL be 1 exactly in IDLE.
REQ-015 SHALL accept a request on a rising edge where req_valid & req_ready, latch its payload, and leave IDLE.
REQ-016 SHALL decode a DRAM hit when DRAM_BASE <= addr < DRAM_BASE+DEPTH and addr is a multiple of DATA_BYTES; offset = addr - DRAM_BASE.
REQ-017 SHALL decode a UART hit when UART_BASE <= addr < UART_BASE+UART_SIZE, with any alignment.
REQ-018 SHALL treat every other address, including a misaligned address inside the DRAM window, as an error access.
REQ-019 DRAM write: on the acceptance edge, byte mem[offset+i] SHALL take wdata[8i+7:8i] for each set wstrb[i]; bytes with clear strobes are unchanged; resp_valid SHALL rise 1 cycle later.
REQ-020 DRAM read: resp_valid SHALL rise READ_LATENCY cycles after the acceptance edge; resp_rdata byte i SHALL equal mem[offset+i] (little-endian).
REQ-021 Error access: resp_valid SHALL rise 1 cycle after acceptance with resp_error=1 and resp_rdata=0; memory and the TX queue SHALL be unchanged.
REQ-022 UART write with wstrb[0]=1: wdata[7:0] SHALL be pushed into the TX queue; while the queue is full, the FSM SHALL stay in WAIT and push in the first cycle space exists; resp_valid SHALL rise the cycle after the push.
REQ-023 UART write with wstrb[0]=0: no push; respond 1 cycle after acceptance.
REQ-024 UART read: resp_rdata bit0 SHALL be 1 when the queue is not full and bit1 SHALL be 1 when the queue is empty; all other bits SHALL be 0, and resp_error=0.
REQ-025 In RESP, resp_valid, resp_rdata and resp_error SHALL be held stable until resp_ready=1; the FSM SHALL then enter IDLE on that edge.
REQ-026 resp_error SHALL be 0 for every DRAM and UART access.
REQ-027 TX queue: tx_valid = not empty and tx_data = oldest entry; an entry SHALL be popped on tx_valid & tx_ready.
REQ-028 A simultaneous push and pop SHALL leave the queue count unchanged; a push SHALL be allowed only when the count at the start of the cycle is < TXQ_DEPTH.
REQ-029 Queue read and write pointers SHALL wrap modulo TXQ_DEPTH.

Reset
REQ-030 While reset=0: state SHALL be IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, TX queue empty, tx_valid=0, tx_data=0.
REQ-031 Reset asserted mid-transaction SHALL abort it with no response; a DRAM write already committed on its acceptance edge SHALL remain.
REQ-032 DRAM contents SHALL NOT be cleared by reset.

Verification
REQ-033 Write 0x11223344 to 0x8000_0010 with wstrb 4'b1111, then read 0x8000_0010 with READ_LATENCY=3 -> rdata 0x11223344, resp_valid 3 cycles after acceptance, error 0.
REQ-034 Write 0xAABBCCDD to 0x8000_0010 with wstrb 4'b0101 over 0x11223344, then read -> 0x11BB33DD.
REQ-035 Read 0x8000_0002 (misaligned) and read 0x0000_0000 -> each gives error 1 and rdata 0 one cycle after acceptance; memory unchanged.
REQ-036 With tx_ready=0, perform 5 UART writes of 'A'..'E', TXQ_DEPTH=4 -> the 5th write stalls in WAIT; raise tx_ready -> bytes drain in order 'A'..'E' and the 5th response completes.
REQ-037 Hold resp_ready=0 for 4 cycles after a read -> resp_valid and resp_rdata stay stable and req_ready stays 0; the response completes on the resp_ready edge.
REQ-038 Assert reset during a READ_LATENCY=4 read -> no resp_valid; after release, req_ready=1 and the TX queue is empty.
